// File: rtl/eth_tx_speed_switch_ctrl.sv
// eth_tx_speed_switch_ctrl: safely retunes the RGMII TX clock generator setting.
// The TX path is drained first, then the generator is reset, and the controller waits for ready.
module eth_tx_speed_switch_ctrl #(
    parameter int reset_cycles_p  = 8,
    parameter int drain_timeout_p = 1024,
    parameter int ready_timeout_p = 4096
) (
    input  logic       clk250_i,
    input  logic       clk250_rst_n_i,
    input  logic       speed_v_i,
    input  logic [1:0] speed_i,
    output logic       speed_ready_o,
    output logic       done_v_o,
    output logic       done_err_o,
    input  logic       tx_busy_i,
    output logic       tx_hold_o,
    output logic       gen_reset_o,
    input  logic       gen_ready_i,
    output logic [1:0] phy_rgmii_tx_clk_setting_o
);
    localparam int max_c = drain_timeout_p > ready_timeout_p
        ? (drain_timeout_p > reset_cycles_p ? drain_timeout_p : reset_cycles_p)
        : (ready_timeout_p > reset_cycles_p ? ready_timeout_p : reset_cycles_p);
    localparam int cw = $clog2(max_c + 1);
    localparam logic [cw-1:0] rst_last   = cw'(reset_cycles_p - 1);
    localparam logic [cw-1:0] drain_last = cw'(drain_timeout_p - 1);
    localparam logic [cw-1:0] ready_last = cw'(ready_timeout_p - 1);

    typedef enum logic [2:0] {BOOT, IDLE, HOLD, RESET, WAIT_READY, DONE} state_t;

    state_t        state, nxt;
    logic [cw-1:0] cnt;
    logic [1:0]    target;
    logic          boot, err, settled, ready_ok;

    assign settled  = cnt >= cw'(2);
    assign ready_ok = settled && gen_ready_i;

    always_comb begin
        nxt = state;
        err = 1'b0;
        case (state)
            BOOT, RESET: if (cnt == rst_last) nxt = WAIT_READY;
            IDLE: if (speed_v_i) begin
                nxt = (speed_i == 2'b11 || speed_i == phy_rgmii_tx_clk_setting_o) ? DONE : HOLD;
                err = speed_i == 2'b11;
            end
            HOLD: if (!tx_busy_i) nxt = RESET;
                  else if (cnt == drain_last) begin
                      nxt = DONE;
                      err = 1'b1;
                  end
            WAIT_READY: if (ready_ok || cnt == ready_last) begin
                nxt = boot ? IDLE : DONE;
                err = !ready_ok;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk250_i or negedge clk250_rst_n_i) begin
        if (!clk250_rst_n_i) begin
            state                      <= BOOT;
            cnt                        <= '0;
            boot                       <= 1'b1;
            target                     <= 2'b00;
            phy_rgmii_tx_clk_setting_o <= 2'b00;
            gen_reset_o                <= 1'b1;
            tx_hold_o                  <= 1'b1;
            speed_ready_o              <= 1'b0;
            done_v_o                   <= 1'b0;
            done_err_o                 <= 1'b0;
        end else begin
            state         <= nxt;
            cnt           <= nxt != state ? '0 : cnt + {{(cw-1){1'b0}}, ~&cnt};
            boot          <= boot && nxt != IDLE;
            if (speed_v_i && speed_ready_o) target <= speed_i;
            if (state == HOLD && nxt == RESET) phy_rgmii_tx_clk_setting_o <= target;
            gen_reset_o   <= nxt == BOOT || nxt == RESET;
            tx_hold_o     <= nxt != IDLE && nxt != DONE;
            speed_ready_o <= nxt == IDLE;
            done_v_o      <= nxt == DONE;
            done_err_o    <= nxt == DONE && err;
        end
    end
endmodule

// File: tb/tb_eth_tx_speed_switch_ctrl.sv
// tb_eth_tx_speed_switch_ctrl: directed vectors and corner sequences for the speed switch controller.
module tb_eth_tx_speed_switch_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       speed_v = 1'b0;
    logic [1:0] speed = 2'b00;
    logic       tx_busy = 1'b0;
    logic       gen_ready = 1'b0;
    logic       speed_ready, done_v, done_err, tx_hold, gen_reset;
    logic [1:0] setting;

    int total = 0, passed = 0;
    int dones = 0, dbl = 0, gr_cnt = 0;
    logic prev_done = 1'b0;

    eth_tx_speed_switch_ctrl dut (
        .clk250_i(clk), .clk250_rst_n_i(rst_n),
        .speed_v_i(speed_v), .speed_i(speed), .speed_ready_o(speed_ready),
        .done_v_o(done_v), .done_err_o(done_err),
        .tx_busy_i(tx_busy), .tx_hold_o(tx_hold),
        .gen_reset_o(gen_reset), .gen_ready_i(gen_ready),
        .phy_rgmii_tx_clk_setting_o(setting)
    );

    always #2 clk = ~clk;

    always @(negedge clk) begin
        if (done_v) begin
            dones++;
            if (prev_done) dbl++;
        end
        prev_done = done_v;
        if (gen_reset) gr_cnt++;
    end

    typedef struct {
        logic       v;
        logic [1:0] sp;
        logic       busy, rdy;
        logic       e_srdy, e_done, e_err, e_hold, e_gr;
        logic [1:0] e_set;
    } vec_t;

    vec_t tbl[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!done_v && n < bound) begin
            tick;
            n++;
        end
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (!speed_ready && n < bound) begin
            tick;
            n++;
        end
    endtask

    task automatic request(input logic [1:0] sp);
        speed_v = 1'b1;
        speed = sp;
        tick;
        speed_v = 1'b0;
    endtask

    initial begin
        int n, d0, g0;
        bit bad;
        // IDLE with setting 00 -> reserved, same-speed, then a full 00->01 switch
        tbl.push_back('{1, 2'd3, 0, 1, 0, 1, 1, 0, 0, 2'd0});
        tbl.push_back('{0, 2'd0, 1, 1, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{1, 2'd0, 0, 1, 0, 1, 0, 0, 0, 2'd0});
        tbl.push_back('{0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{1, 2'd1, 0, 1, 0, 0, 0, 1, 0, 2'd0});
        for (int i = 0; i < 8; i++) tbl.push_back('{0, 2'd0, 0, 1, 0, 0, 0, 1, 1, 2'd1});
        for (int i = 0; i < 3; i++) tbl.push_back('{0, 2'd0, 0, 1, 0, 0, 0, 1, 0, 2'd1});
        tbl.push_back('{0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 2'd1});
        tbl.push_back('{0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 2'd1});

        // reset values and boot sequence
        repeat (2) tick;
        chk("rst_setting", setting, 0);
        chk("rst_gen_reset", gen_reset, 1);
        chk("rst_tx_hold", tx_hold, 1);
        chk("rst_speed_ready", speed_ready, 0);
        chk("rst_done_v", done_v, 0);
        chk("rst_done_err", done_err, 0);
        d0 = dones;
        rst_n = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick;
            if (i == 4) gen_ready = 1'b1;
            if (i == 7) chk("boot_gr_last", gen_reset, 1);
            if (i == 8) chk("boot_gr_off", gen_reset, 0);
            if (i == 10) chk("boot_not_idle", speed_ready, 0);
        end
        chk("boot_idle", speed_ready, 1);
        chk("boot_hold", tx_hold, 0);
        chk("boot_setting", setting, 0);
        chk("boot_no_done", dones - d0, 0);

        foreach (tbl[i]) begin
            speed_v = tbl[i].v;
            speed = tbl[i].sp;
            tx_busy = tbl[i].busy;
            gen_ready = tbl[i].rdy;
            tick;
            chk($sformatf("v%0d_srdy", i), speed_ready, tbl[i].e_srdy);
            chk($sformatf("v%0d_done", i), done_v, tbl[i].e_done);
            if (tbl[i].e_done) chk($sformatf("v%0d_err", i), done_err, tbl[i].e_err);
            chk($sformatf("v%0d_hold", i), tx_hold, tbl[i].e_hold);
            chk($sformatf("v%0d_gr", i), gen_reset, tbl[i].e_gr);
            chk($sformatf("v%0d_set", i), setting, tbl[i].e_set);
        end
        speed_v = 1'b0;
        tx_busy = 1'b0;

        // busy for 50 cycles delays the 01->10 switch
        tx_busy = 1'b1;
        request(2'd2);
        chk("busy_hold", tx_hold, 1);
        chk("busy_srdy", speed_ready, 0);
        bad = 0;
        for (int i = 0; i < 49; i++) begin
            tick;
            if (gen_reset !== 1'b0 || setting !== 2'd1) bad = 1;
        end
        chk("busy_no_reset", bad, 0);
        tx_busy = 1'b0;
        tick;
        chk("busy_drop_gr", gen_reset, 1);
        chk("busy_drop_set", setting, 2);
        wait_done(50, n);
        chk("busy_done_lat", n, 11);
        chk("busy_done_err", done_err, 0);
        chk("busy_done_hold", tx_hold, 0);
        tick;

        // drain timeout: setting stays 10, generator never reset
        tx_busy = 1'b1;
        g0 = gr_cnt;
        request(2'd0);
        wait_done(1100, n);
        chk("drain_to_lat", n, 1024);
        chk("drain_to_err", done_err, 1);
        chk("drain_to_set", setting, 2);
        chk("drain_to_gr", gr_cnt - g0, 0);
        tick;
        tx_busy = 1'b0;

        // ready timeout: new setting retained
        gen_ready = 1'b0;
        request(2'd1);
        wait_done(4200, n);
        chk("ready_to_lat", n, 4105);
        chk("ready_to_err", done_err, 1);
        chk("ready_to_set", setting, 1);
        tick;
        gen_ready = 1'b1;

        // back to 00, then reset in the middle of a 00->10 switch
        request(2'd0);
        wait_done(50, n);
        chk("to00_lat", n, 12);
        chk("to00_err", done_err, 0);
        chk("to00_set", setting, 0);
        tick;
        request(2'd2);
        tick;
        chk("mid_gr", gen_reset, 1);
        chk("mid_set", setting, 2);
        tick;
        tick;
        d0 = dones;
        rst_n = 1'b0;
        #1;
        chk("arst_set", setting, 0);
        chk("arst_gr", gen_reset, 1);
        chk("arst_hold", tx_hold, 1);
        chk("arst_srdy", speed_ready, 0);
        chk("arst_done", done_v, 0);
        tick;
        tick;
        rst_n = 1'b1;
        wait_idle(30, n);
        chk("reboot_lat", n, 11);
        chk("reboot_set", setting, 0);
        chk("reboot_no_done", dones - d0, 0);
        chk("no_double_done", dbl, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
